// File: rtl/axis_noc_injector.sv
// Multi-channel AXI-Stream to NoC flit injector.
// Packet-level round-robin arbitration with credit-based flow control.
module axis_noc_injector #(
    parameter int NUM_CHANNELS      = 4,
    parameter int TDATA_WIDTH       = 64,
    parameter int TID_WIDTH         = 2,
    parameter int TDEST_WIDTH       = 4,
    parameter int DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                                     clk_noc,
    input  logic                                     rst_n,
    input  logic [NUM_CHANNELS-1:0]                  s_tvalid,
    output logic [NUM_CHANNELS-1:0]                  s_tready,
    input  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_CHANNELS-1:0]                  s_tlast,
    input  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]   s_tid,
    input  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0] s_tdest,
    input  logic [NUM_CHANNELS-1:0]                  channel_enable,
    output logic [TDATA_WIDTH-1:0]                   data_out,
    output logic [DEST_WIDTH-1:0]                    dest_out,
    output logic                                     is_tail_out,
    output logic                                     send_out,
    input  logic                                     credit_in,
    output logic [CNT_WIDTH-1:0]                     credits_avail,
    output logic                                     busy,
    output logic                                     credit_overflow
);

    localparam int GW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CNT_WIDTH-1:0] CRED_MAX = CNT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [GW-1:0] LAST_CH = GW'(NUM_CHANNELS - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          owner_q, owner_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0]   credits_q, credits_d;
    logic                   overflow_q, overflow_d;
    logic                   send_q, send_d;
    logic [TDATA_WIDTH-1:0] data_q, data_d;
    logic [DEST_WIDTH-1:0]  dest_q, dest_d;
    logic                   tail_q, tail_d;

    logic [GW-1:0] grant;
    logic          found;
    logic [GW-1:0] sel;
    logic          sel_ok;
    logic          fire;

    // Round-robin search for the first eligible channel after last_grant.
    always_comb begin
        int idx;
        idx   = 0;
        grant = last_grant_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_CHANNELS;
            if (!found && s_tvalid[idx] && channel_enable[idx]) begin
                found = 1'b1;
                grant = GW'(idx);
            end
        end
    end

    // Ready goes only to the owner (locked) or the grant (idle) when a credit exists.
    always_comb begin
        sel      = (state_q == LOCKED) ? owner_q : grant;
        sel_ok   = (state_q == LOCKED) || found;
        s_tready = '0;
        if (rst_n && sel_ok && (credits_q != '0)) begin
            s_tready[sel] = 1'b1;
        end
        fire = s_tvalid[sel] & s_tready[sel];
    end

    // Next-state for arbitration lock, credits and the output flit register.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        credits_d    = credits_q;
        overflow_d   = overflow_q;
        send_d       = fire;
        data_d       = data_q;
        dest_d       = dest_q;
        tail_d       = tail_q;
        if (fire) begin
            data_d = s_tdata[sel];
            dest_d = {s_tid[sel], s_tdest[sel]};
            tail_d = s_tlast[sel];
            if (s_tlast[sel]) begin
                state_d      = IDLE;
                last_grant_d = sel;
            end else begin
                state_d = LOCKED;
                owner_d = sel;
            end
        end
        // Credits are spent at acceptance so in-flight flits are covered.
        if (fire && !credit_in) begin
            credits_d = credits_q - CNT_WIDTH'(1);
        end else if (!fire && credit_in) begin
            if (credits_q == CRED_MAX) begin
                overflow_d = 1'b1;
            end else begin
                credits_d = credits_q + CNT_WIDTH'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= LAST_CH;
            credits_q    <= CRED_MAX;
            overflow_q   <= 1'b0;
            send_q       <= 1'b0;
            data_q       <= '0;
            dest_q       <= '0;
            tail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            credits_q    <= credits_d;
            overflow_q   <= overflow_d;
            send_q       <= send_d;
            data_q       <= data_d;
            dest_q       <= dest_d;
            tail_q       <= tail_d;
        end
    end

    assign data_out        = data_q;
    assign dest_out        = dest_q;
    assign is_tail_out     = tail_q;
    assign send_out        = send_q;
    assign credits_avail   = credits_q;
    assign busy            = (state_q == LOCKED);
    assign credit_overflow = overflow_q;

endmodule

// File: doc/axis_noc_injector.md
Name: axis_noc_injector

Overview:
- Multi-channel injection front end for a router's local port.
- Merges NUM_CHANNELS AXI-Stream sources into one flit stream toward the router input (data/dest/is_tail/send) and obeys credit-based flow control back from the router's flit buffer.
- Arbitration is round-robin at packet granularity: once a channel starts a packet, it owns the port until tlast.
- Generalises the single-source injection shim to N channels with a per-channel enable mask and credit accounting.

Parameters:
NUM_CHANNELS, 4, number of AXIS source channels (>=1)
TDATA_WIDTH, 64, AXIS data width; equals flit width (no serialization)
TID_WIDTH, 2, AXIS tid width
TDEST_WIDTH, 4, AXIS tdest width
DEST_WIDTH, TDEST_WIDTH+TID_WIDTH, flit destination width
FLIT_BUFFER_DEPTH, 4, downstream buffer depth; initial and maximum credit count
CNT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width

Ports:
clk_noc  in  1  NoC clock; single clock domain
rst_n  in  1  reset, synchronous, active-low
s_tvalid  in  [NUM_CHANNELS]  per-channel valid
s_tready  out  [NUM_CHANNELS]  per-channel ready
s_tdata  in  [NUM_CHANNELS][TDATA_WIDTH]  per-channel data
s_tlast  in  [NUM_CHANNELS]  per-channel end of packet
s_tid  in  [NUM_CHANNELS][TID_WIDTH]  per-channel id
s_tdest  in  [NUM_CHANNELS][TDEST_WIDTH]  per-channel destination
channel_enable  in  [NUM_CHANNELS]  arbitration mask; sampled only at packet boundaries
data_out  out  TDATA_WIDTH  flit payload to router
dest_out  out  DEST_WIDTH  flit destination, {tid,tdest}
is_tail_out  out  1  last flit of packet
send_out  out  1  flit valid strobe, one cycle per flit
credit_in  in  1  one-cycle pulse; one downstream buffer slot freed
credits_avail  out  CNT_WIDTH  current credit count
busy  out  1  1 while in LOCKED state
credit_overflow  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0 at a clk_noc edge):
  - send_out, is_tail_out, data_out, dest_out = 0.
  - credits = FLIT_BUFFER_DEPTH.
  - state = IDLE.
  - last_grant = NUM_CHANNELS-1, so channel 0 has first priority.
  - credit_overflow = 0.
  - s_tready is forced to all-zero while rst_n=0.
  - credit_in is ignored during reset.
  - Reset mid-packet drops the lock and discards in-flight accounting. The upstream packet is truncated; this is acceptable and the bench must not flag it.
- Eligibility: channel i is eligible when s_tvalid[i] & channel_enable[i].
- IDLE state:
  - Combinational grant g = first eligible channel searching from last_grant+1 with wrap-around.
  - s_tready[g] = (credits != 0). All other s_tready bits = 0.
  - Fire on g with s_tlast[g]=0: go to LOCKED, owner = g.
  - Fire on g with s_tlast[g]=1: stay IDLE, last_grant = g. This is a single-flit packet.
  - No fire: state and last_grant are unchanged.
- LOCKED state:
  - s_tready[owner] = (credits != 0). All other bits = 0.
  - channel_enable and other channels' valids are ignored.
  - On fire with s_tlast[owner]=1: go to IDLE, last_grant = owner.
- Fire: s_tvalid[c] & s_tready[c].
- Output register, latency 1: a fire in cycle t produces, in cycle t+1:
  - send_out = 1
  - data_out = s_tdata[c]
  - dest_out = {s_tid[c], s_tdest[c]}
  - is_tail_out = s_tlast[c]
- With no fire, send_out = 0 next cycle and data/dest/is_tail hold their previous values.
- Back-to-back fires give continuous send_out. Maximum throughput is one flit per cycle.
- Credits:
  - Decrement on fire, not on send_out, so in-flight flits are covered.
  - Increment on credit_in.
  - Fire and credit_in in the same cycle: unchanged.
  - credits == 0: all s_tready = 0. A credit_in in that cycle enables acceptance from the next cycle; there is no combinational credit_in-to-tready path.
  - credit_in while credits == FLIT_BUFFER_DEPTH with no fire: count saturates and credit_overflow sets (sticky until reset).
- credits_avail reflects the registered count.
- busy = (state == LOCKED).
- A channel dropping s_tvalid mid-packet keeps the lock; the port idles until that channel resumes.

Test Plan:
- Single flit: channel 0 asserts tvalid+tlast with tdata=0xA5, tid=1, tdest=3 -> s_tready[0]=1 the same cycle; the next cycle gives send_out=1, data_out=0xA5, dest_out=6'b01_0011, is_tail_out=1; credits 4->3.
- Round-robin: all 4 channels hold 1-flit packets continuously with credit_in returned each cycle -> grant order 0,1,2,3,0,... and send_out=1 on every cycle.
- Packet lock: channel 1 sends a 3-flit packet while channel 2 is valid throughout -> three consecutive channel-1 flits, is_tail only on the 3rd, then channel 2 is granted; channel_enable[1] dropped mid-packet does not break the lock.
- Credit stall: 5-flit packet with no credit_in -> 4 flits accepted, s_tready=0 and credits_avail=0; one credit_in pulse -> 5th flit accepted the following cycle with is_tail_out=1.
- Simultaneous events: fire and credit_in in the same cycle with credits=2 -> credits stays 2; a credit_in at credits=4 with no fire -> credits stays 4 and credit_overflow=1 (sticky).
- Mid-packet reset: rst_n=0 for 1 cycle during a locked packet -> send_out=0, credits=4, busy=0; the next arbitration starts from channel 0.
